// File: rtl/block_ram_dp.sv
// Dual-port block RAM (A read/write, B read-only) with a zero-fill clear engine; define BLOCK_RAM_DP_OUTREG_EN for an extra output stage.
// Latency: 1 cycle on dout_a/dout_b/collision, 2 cycles with BLOCK_RAM_DP_OUTREG_EN.
// Backpressure: busy=1 while clearing; all port enables and clear requests are ignored, outputs hold.
module block_ram_dp #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int RDW_MODE   = 0,
  parameter int B_BYPASS   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] di_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  input  logic                  en_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] dout_b,
  input  logic                  clear,
  output logic                  busy,
  output logic                  collision
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] IDLE  = 1'b1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] dout_a_q;
  logic [DATA_WIDTH-1:0] dout_b_q;
  logic                  collision_q;
  logic                  idle;
  logic                  wr_a;
  logic                  hit;

  assign idle = (state == IDLE);
  assign busy = ~idle;
  assign wr_a = idle & en_a & we_a;
  assign hit  = wr_a & en_b & (addr_a == addr_b);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
      ptr   <= '0;
    end else if (!idle) begin
      ptr <= ptr + 1'b1;
      if (ptr == {ADDR_WIDTH{1'b1}})
        state <= IDLE;
    end else if (clear) begin
      state <= CLEAR;
      ptr   <= '0;
    end
  end

  // The array has no reset; the clear engine owns the write port while busy.
  always_ff @(posedge clock) begin
    if (!idle)
      mem[ptr] <= '0;
    else if (wr_a)
      mem[addr_a] <= di_a;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout_a_q    <= '0;
      dout_b_q    <= '0;
      collision_q <= 1'b0;
    end else begin
      collision_q <= hit;
      if (idle && en_a)
        dout_a_q <= (we_a && (RDW_MODE == 1)) ? di_a : mem[addr_a];
      if (idle && en_b)
        dout_b_q <= (hit && (B_BYPASS == 1)) ? di_a : mem[addr_b];
    end
  end

`ifdef BLOCK_RAM_DP_OUTREG_EN
  logic [DATA_WIDTH-1:0] dout_a_s2;
  logic [DATA_WIDTH-1:0] dout_b_s2;
  logic                  collision_s2;

  // Free-running stage: advances every cycle, enable-hold lives in stage 1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout_a_s2    <= '0;
      dout_b_s2    <= '0;
      collision_s2 <= 1'b0;
    end else begin
      dout_a_s2    <= dout_a_q;
      dout_b_s2    <= dout_b_q;
      collision_s2 <= collision_q;
    end
  end

  assign dout_a    = dout_a_s2;
  assign dout_b    = dout_b_s2;
  assign collision = collision_s2;
`else
  assign dout_a    = dout_a_q;
  assign dout_b    = dout_b_q;
  assign collision = collision_q;
`endif

endmodule

// File: tb/tb_block_ram_dp.sv
// Bench for block_ram_dp: a READ_FIRST/no-bypass and a WRITE_FIRST/bypass instance share stimulus,
// expected outputs are queued at drive time and popped when their latency expires.
module tb_block_ram_dp;

  localparam int AW = 4;
  localparam int DW = 16;
`ifdef BLOCK_RAM_DP_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic          ea;
    logic          wa;
    logic [AW-1:0] aa;
    logic [DW-1:0] di;
    logic          eb;
    logic [AW-1:0] ab;
  } op_t;

  typedef struct {
    int            due;
    string         tag;
    logic [DW-1:0] a0;
    logic [DW-1:0] b0;
    logic [DW-1:0] a1;
    logic [DW-1:0] b1;
    logic          c;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          en_a, we_a, en_b, clear;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] di_a;
  logic [DW-1:0] dout_a0, dout_b0, dout_a1, dout_b1;
  logic          busy0, busy1, col0, col1;

  int            cyc = 0;
  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] model [16];
  logic [DW-1:0] la0, lb0, la1, lb1;
  exp_t          sbq[$];

  block_ram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(0), .B_BYPASS(0)) dut_rf (
    .clock(clock), .reset(reset), .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .di_a(di_a),
    .dout_a(dout_a0), .en_b(en_b), .addr_b(addr_b), .dout_b(dout_b0), .clear(clear),
    .busy(busy0), .collision(col0)
  );

  block_ram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(1), .B_BYPASS(1)) dut_wf (
    .clock(clock), .reset(reset), .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .di_a(di_a),
    .dout_a(dout_a1), .en_b(en_b), .addr_b(addr_b), .dout_b(dout_b1), .clear(clear),
    .busy(busy1), .collision(col1)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d required=finish", cyc);
    $fatal(1);
  end

  function automatic op_t mk(input logic ea, input logic wa, input logic [AW-1:0] aa,
                             input logic [DW-1:0] di, input logic eb, input logic [AW-1:0] ab);
    op_t o;
    o.ea = ea; o.wa = wa; o.aa = aa; o.di = di; o.eb = eb; o.ab = ab;
    return o;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_model();
    for (int i = 0; i < 16; i++) model[i] = '0;
    la0 = '0; lb0 = '0; la1 = '0; lb1 = '0;
    sbq.delete();
  endtask

  // Drive one idle-state access and queue what both instances must show LAT cycles later.
  task automatic drive(input op_t o, input string tag, input bit push);
    exp_t e;
    logic hit;
    en_a = o.ea; we_a = o.wa; addr_a = o.aa; di_a = o.di; en_b = o.eb; addr_b = o.ab; clear = 1'b0;
    hit = o.ea & o.wa & o.eb & (o.aa == o.ab);
    if (o.ea) begin
      la0 = model[o.aa];
      la1 = o.wa ? o.di : model[o.aa];
    end
    if (o.eb) begin
      lb0 = model[o.ab];
      lb1 = hit ? o.di : model[o.ab];
    end
    if (o.ea && o.wa) model[o.aa] = o.di;
    if (push) begin
      e.due = cyc + LAT; e.tag = tag; e.a0 = la0; e.b0 = lb0; e.a1 = la1; e.b1 = lb1; e.c = hit;
      sbq.push_back(e);
    end
  endtask

  task automatic test_reset();
    op_t  t[$];
    exp_t e;
    int   n;
    reset = 1'b1; en_a = 0; we_a = 0; en_b = 0; clear = 0; addr_a = '0; addr_b = '0; di_a = '0;
    repeat (3) step();
    vectors++;
    if ({dout_a0, dout_b0, dout_a1, dout_b1, col0, col1, busy0, busy1} !== {64'h0, 4'b0011}) begin
      miscompares++;
      $display("FAIL reset_state got a=%h/%h b=%h/%h col=%b%b busy=%b%b want zeros busy=11",
               dout_a0, dout_a1, dout_b0, dout_b1, col0, col1, busy0, busy1);
    end
    reset = 1'b0;
    n = 0;
    while ((busy0 || busy1) && n < 100) begin
      step();
      n++;
    end
    vectors++;
    if (n !== 16 || busy0 !== busy1) begin
      miscompares++;
      $display("FAIL reset_busy_len got %0d cycles (busy %b/%b) want 16", n, busy0, busy1);
    end
    reset_model();
    for (int i = 0; i < 16; i++) t.push_back(mk(1, 0, 4'(i), '0, 1, 4'(15 - i)));
    for (int i = 0; i < t.size() || (sbq.size() > 0 && i < t.size() + 8); i++) begin
      if (i < t.size()) drive(t[i], $sformatf("zero_rd%0d", i), 1'b1);
      else drive(mk(0, 0, 0, 0, 0, 0), "", 1'b0);
      step();
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        vectors++;
        if ({dout_a0, dout_b0, dout_a1, dout_b1, col0, col1} !== {e.a0, e.b0, e.a1, e.b1, e.c, e.c}) begin
          miscompares++;
          $display("FAIL %s got a=%h/%h b=%h/%h col=%b%b want a=%h/%h b=%h/%h col=%b",
                   e.tag, dout_a0, dout_a1, dout_b0, dout_b1, col0, col1, e.a0, e.a1, e.b0, e.b1, e.c);
        end
      end
    end
  endtask

  task automatic test_write_read();
    op_t  t[$];
    exp_t e;
    t.push_back(mk(1, 1, 2, 16'd10, 0, 0));
    t.push_back(mk(1, 1, 3, 16'd15, 0, 0));
    t.push_back(mk(1, 1, 4, 16'd25, 0, 0));
    t.push_back(mk(1, 0, 2, 0, 1, 2));
    t.push_back(mk(1, 0, 3, 0, 1, 3));
    t.push_back(mk(1, 0, 4, 0, 1, 4));
    t.push_back(mk(1, 0, 3, 0, 1, 2));
    for (int i = 0; i < t.size() || (sbq.size() > 0 && i < t.size() + 8); i++) begin
      if (i < t.size()) drive(t[i], $sformatf("wr_rd%0d", i), 1'b1);
      else drive(mk(0, 0, 0, 0, 0, 0), "", 1'b0);
      step();
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        vectors++;
        if ({dout_a0, dout_b0, dout_a1, dout_b1, col0, col1} !== {e.a0, e.b0, e.a1, e.b1, e.c, e.c}) begin
          miscompares++;
          $display("FAIL %s got a=%h/%h b=%h/%h col=%b%b want a=%h/%h b=%h/%h col=%b",
                   e.tag, dout_a0, dout_a1, dout_b0, dout_b1, col0, col1, e.a0, e.a1, e.b0, e.b1, e.c);
        end
      end
    end
  endtask

  task automatic test_enable_hold();
    op_t  t[$];
    exp_t e;
    t.push_back(mk(1, 0, 2, 0, 1, 3));
    t.push_back(mk(0, 1, 4, 16'd20, 0, 4));
    t.push_back(mk(0, 0, 0, 0, 0, 0));
    t.push_back(mk(1, 0, 4, 0, 1, 4));
    for (int i = 0; i < t.size() || (sbq.size() > 0 && i < t.size() + 8); i++) begin
      if (i < t.size()) drive(t[i], $sformatf("en_hold%0d", i), 1'b1);
      else drive(mk(0, 0, 0, 0, 0, 0), "", 1'b0);
      step();
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        vectors++;
        if ({dout_a0, dout_b0, dout_a1, dout_b1, col0, col1} !== {e.a0, e.b0, e.a1, e.b1, e.c, e.c}) begin
          miscompares++;
          $display("FAIL %s got a=%h/%h b=%h/%h col=%b%b want a=%h/%h b=%h/%h col=%b",
                   e.tag, dout_a0, dout_a1, dout_b0, dout_b1, col0, col1, e.a0, e.a1, e.b0, e.b1, e.c);
        end
      end
    end
  endtask

  task automatic test_rdw();
    op_t  t[$];
    exp_t e;
    t.push_back(mk(1, 1, 5, 16'd7, 0, 0));
    t.push_back(mk(1, 1, 5, 16'd9, 0, 0));
    t.push_back(mk(1, 0, 5, 0, 1, 5));
    for (int i = 0; i < t.size() || (sbq.size() > 0 && i < t.size() + 8); i++) begin
      if (i < t.size()) drive(t[i], $sformatf("rdw%0d", i), 1'b1);
      else drive(mk(0, 0, 0, 0, 0, 0), "", 1'b0);
      step();
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        vectors++;
        if ({dout_a0, dout_b0, dout_a1, dout_b1, col0, col1} !== {e.a0, e.b0, e.a1, e.b1, e.c, e.c}) begin
          miscompares++;
          $display("FAIL %s got a=%h/%h b=%h/%h col=%b%b want a=%h/%h b=%h/%h col=%b",
                   e.tag, dout_a0, dout_a1, dout_b0, dout_b1, col0, col1, e.a0, e.a1, e.b0, e.b1, e.c);
        end
      end
    end
  endtask

  task automatic test_collision();
    op_t  t[$];
    exp_t e;
    t.push_back(mk(1, 1, 6, 16'h1234, 0, 0));
    t.push_back(mk(1, 1, 6, 16'h00AA, 1, 6));
    t.push_back(mk(1, 1, 7, 16'h0055, 1, 6));
    t.push_back(mk(0, 1, 6, 16'h0077, 1, 6));
    t.push_back(mk(1, 0, 6, 0, 1, 6));
    for (int i = 0; i < t.size() || (sbq.size() > 0 && i < t.size() + 8); i++) begin
      if (i < t.size()) drive(t[i], $sformatf("collide%0d", i), 1'b1);
      else drive(mk(0, 0, 0, 0, 0, 0), "", 1'b0);
      step();
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        vectors++;
        if ({dout_a0, dout_b0, dout_a1, dout_b1, col0, col1} !== {e.a0, e.b0, e.a1, e.b1, e.c, e.c}) begin
          miscompares++;
          $display("FAIL %s got a=%h/%h b=%h/%h col=%b%b want a=%h/%h b=%h/%h col=%b",
                   e.tag, dout_a0, dout_a1, dout_b0, dout_b1, col0, col1, e.a0, e.a1, e.b0, e.b1, e.c);
        end
      end
    end
  endtask

  task automatic test_clear();
    op_t  t[$];
    exp_t e;
    int   n;
    drive(mk(1, 1, 10, 16'h0077, 1, 6), "clear_req", 1'b1);
    clear = 1'b1;
    step();
    vectors++;
    if ({busy0, busy1} !== 2'b11) begin
      miscompares++;
      $display("FAIL clear_busy_start got %b%b want 11", busy0, busy1);
    end
    n = 0;
    while ((busy0 || busy1) && n < 100) begin
      en_a = 1'b1; we_a = 1'b1; addr_a = 4'(n); di_a = 16'hFFFF; en_b = 1'b1; addr_b = 4'(n); clear = 1'b1;
      step();
      n++;
    end
    en_a = 0; we_a = 0; en_b = 0; clear = 0;
    vectors++;
    if (n !== 16) begin
      miscompares++;
      $display("FAIL clear_busy_len got %0d cycles want 16", n);
    end
    e = sbq.pop_front();
    vectors++;
    if ({dout_a0, dout_b0, dout_a1, dout_b1, col0, col1} !== {e.a0, e.b0, e.a1, e.b1, e.c, e.c}) begin
      miscompares++;
      $display("FAIL %s_hold got a=%h/%h b=%h/%h col=%b%b want a=%h/%h b=%h/%h col=%b",
               e.tag, dout_a0, dout_a1, dout_b0, dout_b1, col0, col1, e.a0, e.a1, e.b0, e.b1, e.c);
    end
    for (int i = 0; i < 16; i++) model[i] = '0;
    // Abort a second clear part-way with reset; the engine must restart a full pass.
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (5) step();
    #2 reset = 1'b1;
    step();
    reset = 1'b0;
    n = 0;
    while ((busy0 || busy1) && n < 100) begin
      step();
      n++;
    end
    vectors++;
    if (n !== 16) begin
      miscompares++;
      $display("FAIL reset_mid_clear_len got %0d cycles want 16", n);
    end
    reset_model();
    for (int i = 0; i < 16; i++) t.push_back(mk(1, 0, 4'(i), '0, 1, 4'(i)));
    for (int i = 0; i < t.size() || (sbq.size() > 0 && i < t.size() + 8); i++) begin
      if (i < t.size()) drive(t[i], $sformatf("cleared_rd%0d", i), 1'b1);
      else drive(mk(0, 0, 0, 0, 0, 0), "", 1'b0);
      step();
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        vectors++;
        if ({dout_a0, dout_b0, dout_a1, dout_b1, col0, col1} !== {e.a0, e.b0, e.a1, e.b1, e.c, e.c}) begin
          miscompares++;
          $display("FAIL %s got a=%h/%h b=%h/%h col=%b%b want a=%h/%h b=%h/%h col=%b",
                   e.tag, dout_a0, dout_a1, dout_b0, dout_b1, col0, col1, e.a0, e.a1, e.b0, e.b1, e.c);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_enable_hold();
    test_rdw();
    test_collision();
    test_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/block_ram_dp.md
Name: block_ram_dp

Overview:
- Parametrised successor to the single-port block RAM: one read/write port (A), one read-only port (B), both synchronous to one clock.
- Adds configurable read-during-write behaviour and a same-address collision flag.
- Adds a hardware clear engine that zero-fills the array after reset or on request.
- Used as the CPU data/instruction memory; port B serves instruction fetch or debug readout.

Parameters:
- DATA_WIDTH, 16: word width in bits.
- ADDR_WIDTH, 10: address width; depth = 2**ADDR_WIDTH words.
- RDW_MODE, 0: port A read-during-write. 0 = READ_FIRST (dout_a returns the old word); 1 = WRITE_FIRST (dout_a returns di_a).
- B_BYPASS, 0: port B collision behaviour. 0 = dout_b returns the old word; 1 = dout_b returns di_a.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- en_a  in  1  port A enable.
- we_a  in  1  port A write enable; qualified by en_a.
- addr_a  in  ADDR_WIDTH  port A address.
- di_a  in  DATA_WIDTH  port A write data.
- dout_a  out  DATA_WIDTH  port A registered read data.
- en_b  in  1  port B read enable.
- addr_b  in  ADDR_WIDTH  port B address.
- dout_b  out  DATA_WIDTH  port B registered read data.
- clear  in  1  request a zero-fill of the whole array; sampled only in IDLE.
- busy  out  1  high while the clear engine owns the array.
- collision  out  1  one-cycle pulse: same-cycle A-write and B-read to the same address.

Behaviour:
- Reset is asynchronous and active-high.
  - Reset values: dout_a=0, dout_b=0, collision=0, busy=1, FSM=CLEAR, clear pointer=0.
  - Array contents are not reset directly; the clear engine overwrites them.
- FSM states: CLEAR, IDLE.
  - CLEAR: each cycle write 0 to mem[ptr], then ptr+1. When ptr == 2**ADDR_WIDTH-1 has been written, go to IDLE next edge.
  - The clear takes exactly 2**ADDR_WIDTH cycles after reset release; busy drops on the edge entering IDLE.
  - IDLE: clear=1 sampled on an edge goes to CLEAR with ptr=0 and busy=1 next cycle. A port access issued in that same cycle is still serviced.
- While busy=1:
  - en_a, we_a and en_b are ignored; no user writes occur.
  - dout_a and dout_b hold their last values.
  - The clear input is ignored; it does not restart the engine.
- Reset asserted mid-clear or mid-access: asynchronously returns to the reset state; the clear restarts from address 0 after release.
- Port A, with en_a=1 and busy=0:
  - Write (we_a=1) to mem[addr_a] on the edge.
  - dout_a updates on the same edge: latency 1 cycle; value per RDW_MODE during a write.
  - en_a=0: dout_a holds its value.
- Port B, with en_b=1 and busy=0: dout_b <= mem[addr_b] on the edge, latency 1. en_b=0: dout_b holds.
- Collision:
  - Condition: en_a & we_a & en_b & (addr_a==addr_b) & ~busy.
  - collision=1 for the cycle after the edge, otherwise 0.
  - dout_b value during a collision follows B_BYPASS.
- Addresses are unsigned with no wrap logic beyond the natural ADDR_WIDTH range. Both ports reading the same address is always legal.

Optional Feature:
- Macro: BLOCK_RAM_DP_OUTREG_EN.
- When defined:
  - A second output register stage is added on dout_a, dout_b and collision; read latency becomes 2 cycles.
  - The stage-2 registers reset to 0 and advance every cycle regardless of enables.
  - The enable-hold behaviour applies to stage 1 only.
- When undefined: latency is 1 cycle as above. No other behaviour differs.

Test Plan:
1. Reset release (ADDR_WIDTH=4) -> busy stays high exactly 16 cycles, then 0. A read of every address then returns 0x0000.
2. Write addr_a=2 di=10, addr_a=3 di=15, addr_a=4 di=25; then read 2,3,4 on port A -> dout_a=10,15,25, one cycle after each address. Port B reads of the same addresses return the same values.
3. RDW_MODE=0: mem[5]=7, write di_a=9 to address 5 -> dout_a=7 that cycle, reads 9 afterwards. RDW_MODE=1 -> dout_a=9 immediately.
4. Same-cycle A-write addr=6 di=0x00AA and B-read addr=6 -> collision pulses 1 for one cycle. dout_b=old (B_BYPASS=0) or 0x00AA (B_BYPASS=1). Different addresses -> collision=0.
5. Assert clear in IDLE after filling data -> busy high 16 cycles. Writes attempted during busy are dropped; all addresses read 0 afterwards. Reset asserted mid-clear -> busy restarts a full 16-cycle count.
6. en_a=0 with we_a=1, addr=4, di=20 -> mem[4] unchanged (still 25) and dout_a holds. With BLOCK_RAM_DP_OUTREG_EN, the test 2 read values appear 2 cycles after the address.
